// File: rtl/min_max_array_loader_if.sv
// Bundles the loader's stream, finder-side and result signals into one port.
// Latency: none (wiring only).
// Backpressure: carried by Din_valid/Din_ready; the result side holds until Result_ack.
interface min_max_array_loader_if #(
  parameter int W  = 8,
  parameter int AW = 4
);
  logic          Go;
  logic [W-1:0]  Din;
  logic          Din_valid;
  logic          Din_ready;
  logic [AW-1:0] Rd_addr;
  logic [W-1:0]  Rd_data;
  logic          Start_out;
  logic          Finder_done;
  logic [W-1:0]  Max_in;
  logic [W-1:0]  Min_in;
  logic [W-1:0]  Max_out;
  logic [W-1:0]  Min_out;
  logic [W-1:0]  Range_out;
  logic          Result_valid;
  logic          Result_ack;
  logic          Error;
  logic          Qi, Ql, Qs, Qw, Qr;

  // Environment side: the producer, the finder and the result consumer.
  modport master (
    output Go, Din, Din_valid, Rd_addr, Finder_done, Max_in, Min_in, Result_ack,
    input  Din_ready, Rd_data, Start_out, Max_out, Min_out, Range_out,
           Result_valid, Error, Qi, Ql, Qs, Qw, Qr
  );

  // Loader side.
  modport slave (
    input  Go, Din, Din_valid, Rd_addr, Finder_done, Max_in, Min_in, Result_ack,
    output Din_ready, Rd_data, Start_out, Max_out, Min_out, Range_out,
           Result_valid, Error, Qi, Ql, Qs, Qw, Qr
  );
endinterface

// File: rtl/min_max_array_loader.sv
// Loads N bytes into a local array, launches the min/max finder and captures Max/Min/Range.
// Latency: LAUNCH on the edge of the last accept; results valid 1 cycle after Finder_done.
// Backpressure: Din_ready only in LOAD; results held in RESULT until Result_ack.
module min_max_array_loader #(
  parameter int N       = 16,
  parameter int W       = 8,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 Clk,
  input  logic                 Reset,
  min_max_array_loader_if.slave bus
);
  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_LOAD   = 5'b00010;
  localparam logic [4:0] S_LAUNCH = 5'b00100;
  localparam logic [4:0] S_WAIT   = 5'b01000;
  localparam logic [4:0] S_RESULT = 5'b10000;

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(N - 1);

  logic [4:0]    state;
  logic [AW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mem [N];
  logic [W-1:0]  max_q, min_q, range_q;
  logic          error_q;
  logic          accept;

  // A byte is taken only while loading; reset blocks a write on its own edge.
  assign accept = (state == S_LOAD) && bus.Din_valid && !Reset;

  // Control FSM, write pointer, timeout counter and result capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      wptr    <= '0;
      cnt     <= '0;
      max_q   <= '0;
      min_q   <= '0;
      range_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Go) begin
            wptr  <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.Din_valid) begin
            wptr <= wptr + 1'b1;
            if (wptr == PTR_LAST) state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // A done seen on the final counted cycle still wins over the timeout.
          if (bus.Finder_done) begin
            max_q   <= bus.Max_in;
            min_q   <= bus.Min_in;
            range_q <= bus.Max_in - bus.Min_in;
            error_q <= 1'b0;
            state   <= S_RESULT;
          end else if (cnt == CNT_LAST) begin
            max_q   <= '0;
            min_q   <= '0;
            range_q <= '0;
            error_q <= 1'b1;
            state   <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (bus.Result_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array storage; contents survive reset and change only during LOAD.
  always_ff @(posedge Clk) begin
    if (accept) mem[wptr] <= bus.Din;
  end

  assign bus.Rd_data      = mem[bus.Rd_addr];
  assign bus.Din_ready    = (state == S_LOAD);
  assign bus.Start_out    = (state == S_LAUNCH);
  assign bus.Result_valid = (state == S_RESULT);
  assign bus.Max_out      = max_q;
  assign bus.Min_out      = min_q;
  assign bus.Range_out    = range_q;
  assign bus.Error        = error_q;
  assign bus.Qi           = (state == S_IDLE);
  assign bus.Ql           = (state == S_LOAD);
  assign bus.Qs           = (state == S_LAUNCH);
  assign bus.Qw           = (state == S_WAIT);
  assign bus.Qr           = (state == S_RESULT);
endmodule

// File: tb/tb_min_max_array_loader.sv
// Self-checking bench: random streams and a finder model against a reference min/max.
// Latency: checks launch on the last-accept edge and results one cycle after done.
// Backpressure: random Din_valid gaps and a held-off Result_ack window.
module tb_min_max_array_loader;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  min_max_array_loader_if #(.W(8), .AW(4)) bus ();

  min_max_array_loader #(.N(16), .W(8), .AW(4), .TIMEOUT(64)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] cur [16];
  logic [7:0] ref_max, ref_min, ref_rng;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain scan of the array for largest and smallest value.
  task automatic ref_model();
    ref_max = 8'h00;
    ref_min = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      if (cur[i] > ref_max) ref_max = cur[i];
      if (cur[i] < ref_min) ref_min = cur[i];
    end
    ref_rng = ref_max - ref_min;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Go, then stream cur[0..n-1]; with gaps Din_valid is randomly withheld.
  task automatic load_array(input bit gaps, input int n_accept);
    int  accepted;
    int  cyc;
    bit  v;
    logic rdy;
    chk("idle_before_go", bus.Qi, 1);
    bus.Go = 1'b1;
    tick();
    bus.Go = 1'b0;
    chk("load_state", bus.Ql, 1);
    accepted = 0;
    cyc = 0;
    while (accepted < n_accept && cyc < 500) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.Din_valid = v;
      bus.Din = v ? cur[accepted] : 8'($urandom);
      rdy = bus.Din_ready;
      tick();
      cyc++;
      if (v && rdy) accepted++;
    end
    chk("accept_count", 32'(accepted), 32'(n_accept));
    // Keep junk on the stream afterwards; it must not reach the array.
    bus.Din_valid = 1'b1;
    bus.Din = 8'hEE;
    if (n_accept == 16) begin
      chk("launch_start", bus.Start_out, 1);
      chk("launch_ready_low", bus.Din_ready, 0);
    end
  endtask

  // Finder model: reads the array through Rd_addr, answers after `delay` cycles.
  task automatic run_finder(input int delay);
    logic [7:0] mx, mn;
    tick();
    chk("start_one_cycle", bus.Start_out, 0);
    chk("wait_state", bus.Qw, 1);
    mx = 8'h00;
    mn = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      bus.Rd_addr = 4'(i);
      #1;
      chk("rd_data", bus.Rd_data, cur[i]);
      if (bus.Rd_data > mx) mx = bus.Rd_data;
      if (bus.Rd_data < mn) mn = bus.Rd_data;
    end
    bus.Din_valid = 1'b0;
    tick();
    repeat (delay) tick();
    bus.Finder_done = 1'b1;
    bus.Max_in = mx;
    bus.Min_in = mn;
    tick();
    bus.Finder_done = 1'b0;
    bus.Max_in = 8'($urandom);
    bus.Min_in = 8'($urandom);
    ref_model();
    chk("result_valid", bus.Result_valid, 1);
    chk("max_out", bus.Max_out, ref_max);
    chk("min_out", bus.Min_out, ref_min);
    chk("range_out", bus.Range_out, ref_rng);
    chk("error_clear", bus.Error, 0);
  endtask

  // Hold off the ack with noise on ignored inputs, then acknowledge.
  task automatic hold_and_ack(input int hold, input logic [31:0] exp_pk);
    for (int k = 0; k < hold; k++) begin
      bus.Go          = 1'($urandom);
      bus.Din_valid   = 1'($urandom);
      bus.Din         = 8'($urandom);
      bus.Finder_done = 1'($urandom);
      bus.Max_in      = 8'($urandom);
      bus.Min_in      = 8'($urandom);
      tick();
      chk("hold_stable", {5'd0, bus.Qr, bus.Result_valid, bus.Error,
                          bus.Max_out, bus.Min_out, bus.Range_out}, exp_pk);
    end
    bus.Go = 1'b0;
    bus.Din_valid = 1'b0;
    bus.Finder_done = 1'b0;
    bus.Result_ack = 1'b1;
    tick();
    bus.Result_ack = 1'b0;
    chk("ack_to_idle", bus.Qi, 1);
    chk("valid_drop", bus.Result_valid, 0);
    chk("values_kept", {8'd0, bus.Max_out, bus.Min_out, bus.Range_out},
        {8'd0, exp_pk[23:0]});
  endtask

  function automatic logic [31:0] pk_ok();
    return {5'd0, 1'b1, 1'b1, 1'b0, ref_max, ref_min, ref_rng};
  endfunction

  task automatic normal_run(input bit gaps, input int delay, input int hold);
    load_array(gaps, 16);
    run_finder(delay);
    hold_and_ack(hold, pk_ok());
  endtask

  initial begin
    int n;
    bus.Go = 0; bus.Din = 0; bus.Din_valid = 0; bus.Rd_addr = 0;
    bus.Finder_done = 0; bus.Max_in = 0; bus.Min_in = 0; bus.Result_ack = 0;
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    chk("rst_idle", bus.Qi, 1);
    chk("rst_onehot", {bus.Qi, bus.Ql, bus.Qs, bus.Qw, bus.Qr}, 5'b10000);
    chk("rst_ready", bus.Din_ready, 0);
    chk("rst_start", bus.Start_out, 0);
    chk("rst_valid", bus.Result_valid, 0);
    chk("rst_error", bus.Error, 0);
    chk("rst_outs", {bus.Max_out, bus.Min_out, bus.Range_out}, 0);

    // Ascending 10..1F, no gaps.
    for (int i = 0; i < 16; i++) cur[i] = 8'h10 + 8'(i);
    normal_run(1'b0, 3, 2);
    chk("asc_expected", {ref_max, ref_min, ref_rng}, 24'h1F100F);

    // Extremes with random gaps.
    for (int i = 0; i < 16; i++) cur[i] = 8'($urandom_range(1, 254));
    cur[0] = 8'h80; cur[1] = 8'h03; cur[2] = 8'hFF; cur[3] = 8'h00; cur[4] = 8'h7F;
    normal_run(1'b1, 5, 2);
    chk("ext_expected", {ref_max, ref_min, ref_rng}, 24'hFF00FF);

    // All equal.
    for (int i = 0; i < 16; i++) cur[i] = 8'h5A;
    normal_run(1'b1, 0, 2);
    chk("eq_expected", {ref_max, ref_min, ref_rng}, 24'h5A5A00);

    // Finder never answers.
    for (int i = 0; i < 16; i++) cur[i] = 8'($urandom);
    load_array(1'b0, 16);
    bus.Din_valid = 1'b0;
    bus.Max_in = 8'hA5;
    bus.Min_in = 8'h11;
    n = 0;
    tick();
    while (bus.Qw && n < 200) begin
      n++;
      tick();
    end
    chk("timeout_cycles", 32'(n), 64);
    chk("timeout_result", bus.Qr, 1);
    chk("timeout_error", bus.Error, 1);
    chk("timeout_outs", {bus.Max_out, bus.Min_out, bus.Range_out}, 0);
    hold_and_ack(3, {5'd0, 1'b1, 1'b1, 1'b1, 24'd0});

    // Normal run after a timeout clears Error; long ack hold-off.
    for (int i = 0; i < 16; i++) cur[i] = 8'($urandom);
    normal_run(1'b1, 7, 20);

    // Reset part way through a load, then a fresh load from index 0.
    for (int i = 0; i < 16; i++) cur[i] = 8'hC0 + 8'(i);
    load_array(1'b1, 7);
    bus.Din_valid = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_idle", bus.Qi, 1);
    chk("midrst_ready", bus.Din_ready, 0);
    for (int i = 0; i < 16; i++) cur[i] = 8'($urandom);
    normal_run(1'b1, 2, 2);

    // Random arrays, gaps and finder delays.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) cur[i] = 8'($urandom);
      normal_run(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
